imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Sits between the single-port instruction memory and its two requesters:
//  - the instruction-fetch stage (read-only);
//  - the boot loader (program download and read-back).
//  Holds the core stalled in BOOT while the loader owns memory, then
//  round-robins both requesters in RUN. Applies the memory's protection
//  rules: out-of-range reads return 0 (NOP), misaligned fetches are flagged.
// PARAMETERS
//  SIZE           1024  memory depth in 32-bit words (power of 2)
//  BOOT_ON_RESET  1     1: leave reset in BOOT; 0: leave reset in RUN
// PORTS
//  clk          in   1             clock, rising edge
//  rst_n        in   1             reset, synchronous, active-low
//  if_req       in   1             fetch read request, held until if_gnt
//  if_addr      in   32            fetch byte address
//  if_gnt       out  1             fetch request accepted this cycle
//  if_rvalid    out  1             fetch read data valid
//  if_rdata     out  32            fetch read data
//  if_err       out  1             misaligned fetch, qualified by if_rvalid
//  ld_req       in   1             loader request, held until ld_gnt
//  ld_we        in   1             1 = write, 0 = read
//  ld_addr      in   32            loader byte address
//  ld_wdata     in   32            loader write data
//  ld_gnt       out  1             loader request accepted this cycle
//  ld_rvalid    out  1             loader read data valid
//  ld_rdata     out  32            loader read data
//  boot_done    in   1             1-cycle pulse: download complete
//  cpu_stall    out  1             high while in BOOT
//  ld_wcount    out  16            accepted loader writes, saturating at 16'hFFFF
//  mem_en       out  1             memory access strobe
//  mem_we       out  1             memory write enable
//  mem_addr     out  $clog2(SIZE)  word index (byte addr[31:2])
//  mem_wdata    out  32            write data to memory
//  mem_rdata    in   32            read data, valid 1 cycle after mem_en && !mem_we
// BEHAVIOUR
//  Reset (synchronous, active-low):
//   - state = BOOT if BOOT_ON_RESET else RUN.
//   - All other outputs 0, ld_wcount = 0, rr pointer = fetch.
//   - cpu_stall = 1 if BOOT_ON_RESET, else 0.
//   - A read pending across reset is dropped: no rvalid after reset.
//  FSM:
//   - BOOT: only loader is granted; if_gnt = 0; cpu_stall = 1.
//   - BOOT -> RUN on the clock edge where boot_done = 1. A same-cycle
//     ld request is still served in BOOT.
//   - RUN: boot_done is ignored. No exit except reset.
//  Arbitration in RUN:
//   - At most one grant per cycle; grants are combinational from req.
//   - Both requesting: grant the one not granted last (rr pointer).
//   - Only one requesting: grant it immediately; the rr pointer still updates.
//  Address checks (granted request only):
//   - Word index = addr[31:2].
//   - In range: addr[31:2] < SIZE and addr[1:0] == 0. Drive
//     mem_en = 1, mem_we = ld_we (0 for fetch), mem_addr, mem_wdata.
//   - Out of range read: mem_en = 0; rvalid next cycle with rdata = 0.
//   - Misaligned fetch: mem_en = 0; next cycle if_rvalid = 1, if_err = 1,
//     if_rdata = 0.
//   - Misaligned or out-of-range loader write: granted but dropped;
//     mem_en = 0 and ld_wcount is unchanged.
//  Read latency and writes:
//   - Reads: rvalid to the granted requester exactly 1 cycle after grant.
//   - Back-to-back grants give back-to-back rvalids.
//   - Writes produce no rvalid.
//   - ld_wcount += 1 per accepted in-range aligned write; it holds at 16'hFFFF.
// TESTING
//  1. Reset with BOOT_ON_RESET=1, then if_req=1 for 10 cycles
//     -> if_gnt=0, cpu_stall=1 throughout.
//  2. In BOOT, loader writes 00000093, DEADBEEF, CAFEBABE to addr 0/4/8;
//     pulse boot_done; fetch reads 0/4/8
//     -> ld_wcount=3, cpu_stall=0, if_rdata = those three words, each
//        1 cycle after its grant.
//  3. RUN, if_req and ld_req (read 4) held 4 cycles
//     -> grants alternate if, ld, if, ld; each rvalid lands 1 cycle
//        after its grant.
//  4. Fetch 32'd8000 -> mem_en=0, if_rvalid=1, if_rdata=0, if_err=0.
//     Fetch 32'h6 -> if_err=1, if_rdata=0.
//  5. Assert rst_n=0 in the cycle after a fetch grant
//     -> no if_rvalid afterwards; state returns to BOOT, ld_wcount=0.
//  6. Force ld_wcount to 16'hFFFE, perform 3 writes -> ld_wcount = 16'hFFFF.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
// Shares the single-port instruction memory between the fetch stage and the
// boot loader. The loader owns the memory in BOOT while the core is stalled.
// In RUN the two requesters are round-robined. Out-of-range reads return 0,
// misaligned fetches are flagged, and bad loader writes are swallowed.
module imem_access_arbiter #(
  parameter int SIZE          = 1024,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [31:0]             if_rdata,
  output logic                    if_err,
  input  logic                    ld_req,
  input  logic                    ld_we,
  input  logic [31:0]             ld_addr,
  input  logic [31:0]             ld_wdata,
  output logic                    ld_gnt,
  output logic                    ld_rvalid,
  output logic [31:0]             ld_rdata,
  input  logic                    boot_done,
  output logic                    cpu_stall,
  output logic [15:0]             ld_wcount,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [$clog2(SIZE)-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam int          AW     = $clog2(SIZE);
  localparam logic [31:0] SIZE_W = 32'(SIZE);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = BOOT_ON_RESET ? BOOT : RUN;

  state_t      state_reg, state_next;
  // 1 when the loader was the most recent grant; fetch wins the next tie.
  logic        last_ld_reg, last_ld_next;
  logic [15:0] ld_wcount_reg, ld_wcount_next;

  // Response pipeline: one stage, matching the memory's read latency.
  logic        if_rvalid_reg;
  logic        if_err_reg;
  logic        if_zero_reg;
  logic        ld_rvalid_reg;
  logic        ld_zero_reg;

  logic        if_aligned, if_ok;
  logic        ld_ok;

  // Address qualification: word index must be below SIZE and byte offset zero.
  always_comb begin
    if_aligned = (if_addr[1:0] == 2'b00);
    if_ok      = if_aligned && ({2'b00, if_addr[31:2]} < SIZE_W);
    ld_ok      = (ld_addr[1:0] == 2'b00) && ({2'b00, ld_addr[31:2]} < SIZE_W);
  end

  // Next state, grants and memory strobes; nothing is granted while in reset.
  always_comb begin
    state_next     = state_reg;
    last_ld_next   = last_ld_reg;
    ld_wcount_next = ld_wcount_reg;
    if_gnt         = 1'b0;
    ld_gnt         = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    if (rst_n) begin
      case (state_reg)
        BOOT: begin
          // Loader may still be served on the cycle boot_done arrives.
          ld_gnt = ld_req;
          if (boot_done) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (if_req && ld_req) begin
            if_gnt = last_ld_reg;
            ld_gnt = !last_ld_reg;
          end else begin
            if_gnt = if_req;
            ld_gnt = ld_req;
          end
        end
      endcase

      if (if_gnt || ld_gnt) begin
        last_ld_next = ld_gnt;
      end

      if (if_gnt && if_ok) begin
        mem_en   = 1'b1;
        mem_addr = if_addr[AW+1:2];
      end

      if (ld_gnt && ld_ok) begin
        mem_en   = 1'b1;
        mem_we   = ld_we;
        mem_addr = ld_addr[AW+1:2];
        if (ld_we) begin
          mem_wdata = ld_wdata;
          if (ld_wcount_reg != 16'hFFFF) begin
            ld_wcount_next = ld_wcount_reg + 16'd1;
          end
        end
      end
    end
  end

  // State, rr pointer, write counter and the one-cycle response pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= RESET_STATE;
      last_ld_reg   <= 1'b0;
      ld_wcount_reg <= 16'd0;
      if_rvalid_reg <= 1'b0;
      if_err_reg    <= 1'b0;
      if_zero_reg   <= 1'b0;
      ld_rvalid_reg <= 1'b0;
      ld_zero_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_ld_reg   <= last_ld_next;
      ld_wcount_reg <= ld_wcount_next;
      if_rvalid_reg <= if_gnt;
      if_err_reg    <= if_gnt && !if_aligned;
      if_zero_reg   <= if_gnt && !if_ok;
      ld_rvalid_reg <= ld_gnt && !ld_we;
      ld_zero_reg   <= ld_gnt && !ld_we && !ld_ok;
    end
  end

  // Rejected accesses return 0 (NOP) instead of stale memory output.
  always_comb begin
    cpu_stall = (state_reg == BOOT);
    ld_wcount = ld_wcount_reg;
    if_rvalid = if_rvalid_reg;
    if_err    = if_err_reg;
    if_rdata  = (if_rvalid_reg && !if_zero_reg) ? mem_rdata : 32'd0;
    ld_rvalid = ld_rvalid_reg;
    ld_rdata  = (ld_rvalid_reg && !ld_zero_reg) ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a small behavioural memory.
module tb_imem_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        boot_done;
  logic        cpu_stall;
  logic [15:0] ld_wcount;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp;
  int n_bad;

  logic [31:0] mem [0:1023];

  imem_access_arbiter #(.SIZE(1024), .BOOT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .boot_done(boot_done), .cpu_stall(cpu_stall), .ld_wcount(ld_wcount),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory model, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = 32'd0; ld_wdata = 32'd0; boot_done = 1'b0;
    cyc(); cyc();
    #1;
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall got %b want 1", cpu_stall); end
    n_cmp++; if (ld_wcount !== 16'd0) begin n_bad++; $display("FAIL rst_wcount got %h want 0000", ld_wcount); end
    n_cmp++; if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %b%b want 00", if_rvalid, ld_rvalid); end
    n_cmp++; if (mem_en !== 1'b0 || if_gnt !== 1'b0 || ld_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_strobes got %b%b%b want 000", mem_en, if_gnt, ld_gnt); end
    rst_n = 1'b1;
    cyc();
    if_req = 1'b1; if_addr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("FAIL boot_if_gnt[%0d] got %b want 0", i, if_gnt); end
      n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL boot_stall[%0d] got %b want 1", i, cpu_stall); end
      cyc();
    end
    if_req = 1'b0;
    $display("txn reset+boot fetch blocked for 10 cycles");
  endtask

  task automatic test_boot_load();
    logic [31:0] words [0:2];
    words[0] = 32'h00000093; words[1] = 32'hDEADBEEF; words[2] = 32'hCAFEBABE;
    for (int i = 0; i < 3; i++) begin
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'(4 * i); ld_wdata = words[i];
      boot_done = (i == 2);
      #1;
      n_cmp++; if (ld_gnt !== 1'b1) begin n_bad++; $display("FAIL ld_wr_gnt[%0d] got %b want 1", i, ld_gnt); end
      n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== words[i]) begin
        n_bad++; $display("FAIL ld_wr_mem[%0d] got en=%b we=%b a=%0d d=%h want 1 1 %0d %h", i, mem_en, mem_we, mem_addr, mem_wdata, i, words[i]);
      end
      $display("txn loader write addr=%h data=%h", ld_addr, ld_wdata);
      cyc();
    end
    boot_done = 1'b0;
    // Misaligned loader write in RUN: granted, dropped.
    ld_addr = 32'd2; ld_wdata = 32'h12345678;
    #1;
    n_cmp++; if (ld_gnt !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL ld_misaligned_wr got gnt=%b en=%b want 1 0", ld_gnt, mem_en); end
    cyc();
    ld_req = 1'b0; ld_we = 1'b0;
    #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL run_stall got %b want 0", cpu_stall); end
    n_cmp++; if (ld_wcount !== 16'd3) begin n_bad++; $display("FAIL wcount3 got %h want 0003", ld_wcount); end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        if_req = 1'b1; if_addr = 32'(4 * i);
        #1;
        n_cmp++; if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'(i)) begin
          n_bad++; $display("FAIL fetch_gnt[%0d] got g=%b en=%b we=%b a=%0d want 1 1 0 %0d", i, if_gnt, mem_en, mem_we, mem_addr, i);
        end
      end else begin
        if_req = 1'b0;
      end
      if (i > 0) begin
        n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== words[i-1]) begin
          n_bad++; $display("FAIL fetch_data[%0d] got v=%b d=%h want 1 %h", i - 1, if_rvalid, if_rdata, words[i-1]);
        end
        $display("txn fetch addr=%0d data=%h", 4 * (i - 1), if_rdata);
      end
      cyc();
    end
    n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_idle got %b want 0", if_rvalid); end
    // Loader read-back in RUN; leaves the loader as last grant.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'd4;
    #1;
    n_cmp++; if (ld_gnt !== 1'b1) begin n_bad++; $display("FAIL ld_rd_gnt got %b want 1", ld_gnt); end
    cyc();
    ld_req = 1'b0;
    n_cmp++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_rd_data got v=%b d=%h want 1 deadbeef", ld_rvalid, ld_rdata); end
    $display("txn loader read addr=4 data=%h", ld_rdata);
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp_if [0:3];
    exp_if[0] = 1'b1; exp_if[1] = 1'b0; exp_if[2] = 1'b1; exp_if[3] = 1'b0;
    if_req = 1'b1; if_addr = 32'd8; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'd4;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin if_req = 1'b0; ld_req = 1'b0; end
      #1;
      if (i < 4) begin
        n_cmp++; if (if_gnt !== exp_if[i] || ld_gnt !== !exp_if[i]) begin
          n_bad++; $display("FAIL rr_gnt[%0d] got if=%b ld=%b want %b %b", i, if_gnt, ld_gnt, exp_if[i], !exp_if[i]);
        end
      end
      if (i > 0) begin
        n_cmp++; if (if_rvalid !== exp_if[i-1] || ld_rvalid !== !exp_if[i-1]) begin
          n_bad++; $display("FAIL rr_rvalid[%0d] got if=%b ld=%b want %b %b", i - 1, if_rvalid, ld_rvalid, exp_if[i-1], !exp_if[i-1]);
        end
        n_cmp++; if (exp_if[i-1] ? (if_rdata !== 32'hCAFEBABE) : (ld_rdata !== 32'hDEADBEEF)) begin
          n_bad++; $display("FAIL rr_data[%0d] got if=%h ld=%h", i - 1, if_rdata, ld_rdata);
        end
        $display("txn rr slot %0d granted %s", i - 1, exp_if[i-1] ? "fetch" : "loader");
      end
      cyc();
    end
  endtask

  task automatic test_addr_checks();
    // Aligned but beyond depth (word 2000).
    if_req = 1'b1; if_addr = 32'd8000;
    #1;
    n_cmp++; if (if_gnt !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL oor_fetch got gnt=%b en=%b want 1 0", if_gnt, mem_en); end
    cyc();
    // Misaligned fetch in the very next cycle.
    if_addr = 32'h6;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'd0 || if_err !== 1'b0) begin
      n_bad++; $display("FAIL oor_fetch_rsp got v=%b d=%h e=%b want 1 0 0", if_rvalid, if_rdata, if_err);
    end
    $display("txn fetch addr=8000 out of range");
    #1;
    n_cmp++; if (if_gnt !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL mis_fetch got gnt=%b en=%b want 1 0", if_gnt, mem_en); end
    cyc();
    if_req = 1'b0;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'd0 || if_err !== 1'b1) begin
      n_bad++; $display("FAIL mis_fetch_rsp got v=%b d=%h e=%b want 1 0 1", if_rvalid, if_rdata, if_err);
    end
    $display("txn fetch addr=6 misaligned");
    // Loader read at word SIZE (first out-of-range index).
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h1000;
    #1;
    n_cmp++; if (ld_gnt !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL oor_ld_rd got gnt=%b en=%b want 1 0", ld_gnt, mem_en); end
    cyc();
    // Loader write at word SIZE-1 (last in-range index).
    ld_we = 1'b1; ld_addr = 32'hFFC; ld_wdata = 32'hA5A5_0001;
    n_cmp++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'd0) begin n_bad++; $display("FAIL oor_ld_rsp got v=%b d=%h want 1 0", ld_rvalid, ld_rdata); end
    #1;
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd1023) begin
      n_bad++; $display("FAIL top_wr got en=%b we=%b a=%0d want 1 1 1023", mem_en, mem_we, mem_addr);
    end
    cyc();
    // Loader write at word SIZE: dropped.
    ld_addr = 32'h1000;
    #1;
    n_cmp++; if (ld_gnt !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL oor_wr got gnt=%b en=%b want 1 0", ld_gnt, mem_en); end
    cyc();
    ld_req = 1'b0; ld_we = 1'b0;
    n_cmp++; if (ld_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got %b want 0", ld_rvalid); end
    n_cmp++; if (ld_wcount !== 16'd4) begin n_bad++; $display("FAIL wcount4 got %h want 0004", ld_wcount); end
    $display("txn loader boundary accesses wcount=%0d", ld_wcount);
    cyc();
  endtask

  task automatic test_reset_drop();
    if_req = 1'b1; if_addr = 32'd0;
    #1;
    n_cmp++; if (if_gnt !== 1'b1) begin n_bad++; $display("FAIL pre_rst_gnt got %b want 1", if_gnt); end
    cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if_gnt !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL in_rst_gnt got gnt=%b en=%b want 0 0", if_gnt, mem_en); end
    cyc();
    if_req = 1'b0;
    n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_drop_rvalid got %b want 0", if_rvalid); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rst_back_boot got %b want 1", cpu_stall); end
    n_cmp++; if (ld_wcount !== 16'd0) begin n_bad++; $display("FAIL rst_wcount_clr got %h want 0000", ld_wcount); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("FAIL post_rst_rvalid got %b want 0", if_rvalid); end
    $display("txn reset during pending fetch");
  endtask

  task automatic test_wcount_saturate();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'd16; ld_wdata = 32'h0;
    repeat (65534) @(posedge clk);
    #1;
    n_cmp++; if (ld_wcount !== 16'hFFFE) begin n_bad++; $display("FAIL wcount_fffe got %h want fffe", ld_wcount); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (ld_wcount !== 16'hFFFF) begin n_bad++; $display("FAIL wcount_sat[%0d] got %h want ffff", i, ld_wcount); end
      $display("txn loader write %0d past fffe wcount=%h", i, ld_wcount);
    end
    ld_req = 1'b0; ld_we = 1'b0;
    cyc();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mem_rdata = 32'd0;
    test_reset();
    test_boot_load();
    test_round_robin();
    test_addr_checks();
    test_reset_drop();
    test_wcount_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
